// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode constants, the NOP encoding and the fetch state enum.
// No logic; latency and backpressure are not applicable.
// Imported by fetch_unit and pc_next_sel.
package rv32i_pkg;

   localparam logic [6:0]  OP_JAL    = 7'b1101111;
   localparam logic [6:0]  OP_JALR   = 7'b1100111;
   localparam logic [6:0]  OP_BRANCH = 7'b1100011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ISSUE = 2'd2,
      ST_FAULT = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (jalr > jal/taken branch > pc+4) with misaligned-target detect.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module pc_next_sel
   import rv32i_pkg::*;
#(
   parameter bit TRAP_EN = 1'b0
) (
   input  logic [31:0] pc,
   input  logic        jalr_i,
   input  logic        uj,
   input  logic        sb_taken,
   input  logic [31:0] br_target,
   input  logic [31:0] jalr_target,
   output logic [31:0] pc_plus4,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] raw_target;

   always_comb begin
      pc_plus4   = pc + 32'd4;
      raw_target = pc_plus4;
      if (jalr_i) begin
         raw_target = {jalr_target[31:1], 1'b0};
      end else if (uj || sb_taken) begin
         raw_target = br_target;
      end
   end

   // Without the trap, the low bits are simply dropped so the fetch stays word aligned.
   always_comb begin
      if (TRAP_EN) begin
         next_pc    = raw_target;
         misaligned = (raw_target[1:0] != 2'b00);
      end else begin
         next_pc    = {raw_target[31:2], 2'b00};
         misaligned = 1'b0;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: owns the PC, fetches over req/ack, presents a registered instruction.
// Latency: one cycle from imem_ack to instr_valid; at least two cycles per instruction.
// Backpressure: stall holds the presented instruction; FETCH_MISALIGN_TRAP_EN enables the misaligned-target trap.
module fetch_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        sb_taken,
   input  logic        uj,
   input  logic        jalr_i,
   input  logic [31:0] br_target,
   input  logic [31:0] jalr_target,
   output logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [2:0]  func3,
   output logic        func7,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        fetch_fault,
   output logic [31:0] fault_addr
);

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q;
   logic [31:0]  instr_q;
   logic [31:0]  next_pc;
   logic         misaligned;
   logic         load_instr;
   logic         retire;

   pc_next_sel #(
      .TRAP_EN     (TRAP_EN)
   ) u_pc_next_sel (
      .pc          (pc_q),
      .jalr_i      (jalr_i),
      .uj          (uj),
      .sb_taken    (sb_taken),
      .br_target   (br_target),
      .jalr_target (jalr_target),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misaligned  (misaligned)
   );

   always_comb begin
      state_d    = state_q;
      load_instr = 1'b0;
      retire     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               load_instr = 1'b1;
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            // Redirect inputs only matter in the cycle the instruction actually retires.
            if (!stall) begin
               retire  = 1'b1;
               state_d = misaligned ? ST_FAULT : ST_FETCH;
            end
         end
         ST_FAULT: begin
            state_d = ST_FAULT;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         if (load_instr) begin
            instr_q <= imem_rdata;
         end
         if (retire && !misaligned) begin
            pc_q <= next_pc;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fault_q;
   logic [31:0] fault_addr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         fault_q      <= 1'b0;
         fault_addr_q <= 32'h0000_0000;
      end else if (retire && misaligned) begin
         fault_q      <= 1'b1;
         fault_addr_q <= next_pc;
      end
   end

   assign fetch_fault = fault_q;
   assign fault_addr  = fault_addr_q;
`else
   assign fetch_fault = 1'b0;
   assign fault_addr  = 32'h0000_0000;
`endif

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == ST_ISSUE);
   assign instr       = instr_q;
   assign opcode      = instr_q[6:0];
   assign func3       = instr_q[14:12];
   assign func7       = instr_q[30];
   assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed program-flow cases followed by randomized traffic.
// Expected fetch addresses and issued instructions are queued by the driver and checked by a monitor.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        sb_taken = 1'b0;
   logic        uj = 1'b0;
   logic        jalr_i = 1'b0;
   logic [31:0] br_target = 32'h0;
   logic [31:0] jalr_target = 32'h0;
   logic [31:0] instr;
   logic [6:0]  opcode;
   logic [2:0]  func3;
   logic        func7;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        fetch_fault;
   logic [31:0] fault_addr;

   fetch_unit #(
      .RESET_PC    (RST_PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .sb_taken    (sb_taken),
      .uj          (uj),
      .jalr_i      (jalr_i),
      .br_target   (br_target),
      .jalr_target (jalr_target),
      .instr       (instr),
      .opcode      (opcode),
      .func3       (func3),
      .func7       (func7),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .fetch_fault (fetch_fault),
      .fault_addr  (fault_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } iss_t;

   int          total = 0;
   int          bad = 0;
   logic [31:0] fetch_q[$];
   iss_t        issue_q[$];
   logic [31:0] model_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference next-PC: written from the architectural rules, not the mux structure.
   function automatic logic [31:0] ref_next(input logic [31:0] p, input bit j, input bit u,
                                            input bit s, input logic [31:0] bt,
                                            input logic [31:0] jt, output bit flt);
      logic [31:0] t;
      if (j)           t = jt - (jt % 2);
      else if (u || s) t = bt;
      else             t = p + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
      flt = (t % 4) != 0;
`else
      flt = 1'b0;
      t   = t - (t % 4);
`endif
      return t;
   endfunction

   // Monitor: fetch handshakes and presented instructions, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (imem_req && imem_ack) begin
            if (fetch_q.size() == 0) chk("fetch_unexpected", imem_addr, 32'hxxxx_xxxx);
            else                     chk("fetch_addr", imem_addr, fetch_q.pop_front());
         end
         if (instr_valid) begin
            if (issue_q.size() == 0) begin
               chk("issue_unexpected", instr, 32'hxxxx_xxxx);
            end else begin
               chk("issue_pc", pc, issue_q[0].pc);
               chk("issue_instr", instr, issue_q[0].ins);
               chk("issue_pc4", pc_plus4, issue_q[0].pc + 32'd4);
               chk("issue_opcode", {25'd0, opcode}, {25'd0, issue_q[0].ins[6:0]});
               chk("issue_func3", {29'd0, func3}, {29'd0, issue_q[0].ins[14:12]});
               chk("issue_func7", {31'd0, func7}, {31'd0, issue_q[0].ins[30]});
               if (!stall) void'(issue_q.pop_front());
            end
         end
      end
   end

   task automatic reset_dut(input bit late_ack);
      rst = 1'b1;
      imem_ack = 1'b0;
      stall = 1'b0;
      uj = 1'b0; jalr_i = 1'b0; sb_taken = 1'b0;
      fetch_q.delete();
      issue_q.delete();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", pc, RST_PC);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
      chk("rst_fault_addr", fault_addr, 32'd0);
      chk("rst_opcode", {25'd0, opcode}, 32'h13);
      chk("rst_pc4", pc_plus4, RST_PC + 32'd4);
      rst = 1'b0;
      model_pc = RST_PC;
      imem_ack = late_ack;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_no_valid", {31'd0, instr_valid}, 32'd0);
   endtask

   task automatic do_instr(input int lat, input int nstall, input bit j, input bit u, input bit s,
                           input logic [31:0] bt, input logic [31:0] jt);
      logic [31:0] rd;
      logic [31:0] nxt;
      bit          flt;
      chk("req_up", {31'd0, imem_req}, 32'd1);
      fetch_q.push_back(model_pc);
      for (int k = 0; k < lat; k++) begin
         imem_ack = 1'b0;
         @(posedge clk);
         #1;
         chk("req_hold", {31'd0, imem_req}, 32'd1);
         chk("addr_stable", imem_addr, model_pc);
      end
      rd = $urandom;
      imem_rdata = rd;
      imem_ack = 1'b1;
      issue_q.push_back(iss_t'{pc: model_pc, ins: rd});
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      chk("issue_lat", {31'd0, instr_valid}, 32'd1);
      for (int k = 0; k < nstall; k++) begin
         stall = 1'b1;
         uj = k[0];
         jalr_i = 1'($urandom_range(0, 1));
         sb_taken = 1'($urandom_range(0, 1));
         br_target = $urandom;
         jalr_target = $urandom;
         imem_ack = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_no_req", {31'd0, imem_req}, 32'd0);
      end
      stall = 1'b0;
      imem_ack = 1'b0;
      jalr_i = j; uj = u; sb_taken = s;
      br_target = bt; jalr_target = jt;
      nxt = ref_next(model_pc, j, u, s, bt, jt, flt);
      @(posedge clk);
      #1;
      jalr_i = 1'b0; uj = 1'b0; sb_taken = 1'b0;
      br_target = $urandom; jalr_target = $urandom;
      if (flt) begin
         for (int k = 0; k < 4; k++) begin
            chk("fault_flag", {31'd0, fetch_fault}, 32'd1);
            chk("fault_addr", fault_addr, nxt);
            chk("fault_no_req", {31'd0, imem_req}, 32'd0);
            chk("fault_no_valid", {31'd0, instr_valid}, 32'd0);
            @(posedge clk);
            #1;
         end
         reset_dut(1'b0);
      end else begin
         model_pc = nxt;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      int          sel;
      logic [31:0] bt;
      logic [31:0] jt;
      reset_dut(1'b0);
      do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0);                  // 0x100, same-cycle ack
      do_instr(3, 0, 0, 0, 0, 32'h0, 32'h0);                  // 0x104, slow memory
      do_instr(1, 0, 0, 1, 0, 32'h200, 32'h0);                // 0x108, JAL -> 0x200
      do_instr(0, 0, 1, 0, 0, 32'h0, 32'h301);                // JALR 0x301 -> 0x300
      do_instr(2, 4, 1, 0, 1, 32'h500, 32'h400);              // stalls, JALR beats branch
      do_instr(0, 0, 0, 0, 1, 32'h206, 32'h0);                // misaligned branch target
      do_instr(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);          // jump to top of memory
      do_instr(1, 0, 0, 0, 0, 32'h0, 32'h0);                  // wraps to 0
      do_instr(0, 0, 0, 0, 0, 32'h0, 32'h0);                  // at 0x0
      // Reset while a fetch is outstanding, with the ack arriving late.
      chk("midfetch_req", {31'd0, imem_req}, 32'd1);
      rst = 1'b1;
      imem_ack = 1'b1;
      @(posedge clk);
      #1;
      chk("midfetch_drop_req", {31'd0, imem_req}, 32'd0);
      chk("midfetch_no_valid", {31'd0, instr_valid}, 32'd0);
      chk("midfetch_pc", pc, RST_PC);
      chk("midfetch_instr", instr, 32'h0000_0013);
      reset_dut(1'b1);
      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 4);
         bt = $urandom;
         jt = $urandom;
         if ($urandom_range(0, 1) == 1) bt = bt - (bt % 4);
         do_instr($urandom_range(0, 3), $urandom_range(0, 2), sel == 3, sel == 1 || sel == 4,
                  sel == 2 || sel == 4, bt, jt);
      end
      @(posedge clk);
      #1;
      chk("issue_q_drained", issue_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
